vector_floating_point_square_root_sequencer: RTL

// - Sequences one vfsqrt.v / vfrsqrt7.v instruction over a VLEN-bit register, element by element.
// - Drives a shared multi-cycle scalar FP sqrt core through a valid/ready request and a response strobe.
// - Assembles vd and accumulates fflags. Sits between vector issue and the sqrt datapath.

---
 rtl/vector_floating_point_square_root_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/vector_floating_point_square_root_sequencer.sv
// Element-by-element sequencer for vfsqrt.v / vfrsqrt7.v over one VLEN-bit register,
// driving a shared scalar sqrt core. Optional masking is enabled by defining VECTOR_SQRT_MASK_EN.
module vector_floating_point_square_root_sequencer #(
   parameter int VLEN     = 128,
   parameter int VL_WIDTH = $clog2(VLEN/32) + 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic                start_rsqrt7,
   input  logic                start_sew64,
   input  logic [VL_WIDTH-1:0] start_vl,
`ifdef VECTOR_SQRT_MASK_EN
   input  logic                start_vm,
   input  logic [VLEN/32-1:0]  v0_mask,
`endif
   input  logic [VLEN-1:0]     vs2,
   input  logic [VLEN-1:0]     vd_old,
   input  logic                kill,
   output logic                core_req_valid,
   input  logic                core_req_ready,
   output logic [63:0]         core_operand,
   output logic                core_sew64,
   output logic                core_rsqrt7,
   input  logic                core_resp_valid,
   input  logic [63:0]         core_result,
   input  logic [4:0]          core_fflags,
   output logic                done_valid,
   input  logic                done_ready,
   output logic [VLEN-1:0]     vd,
   output logic [4:0]          fflags
);

   localparam int N32 = VLEN / 32;
   localparam int N64 = VLEN / 64;
   localparam logic [VL_WIDTH-1:0] NONE = VL_WIDTH'(N32);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

   state_t              state;
   logic [VL_WIDTH-1:0] index;
   logic [VL_WIDTH-1:0] vl_reg;
   logic [VLEN-1:0]     src;
   logic                sew64_reg;
   logic                rsqrt7_reg;
   logic [VL_WIDTH-1:0] vl_clamped;
   logic [N32-1:0]      start_en;
   logic [N32-1:0]      run_en;
   logic [VL_WIDTH-1:0] first_idx;
   logic [VL_WIDTH-1:0] next_idx;
`ifdef VECTOR_SQRT_MASK_EN
   logic                vm_reg;
   logic [N32-1:0]      mask_reg;
`endif

   // Lowest enabled element at or above 'from'; NONE when nothing is left to do.
   function automatic logic [VL_WIDTH-1:0] first_set(input logic [N32-1:0] en,
                                                     input logic [VL_WIDTH-1:0] from);
      logic [VL_WIDTH-1:0] r;
      r = NONE;
      for (int i = N32 - 1; i >= 0; i--) begin
         if (en[i] && (VL_WIDTH'(i) >= from)) r = VL_WIDTH'(i);
      end
      return r;
   endfunction

   always_comb begin
      vl_clamped = start_vl;
      if (start_sew64) begin
         if (start_vl > VL_WIDTH'(N64)) vl_clamped = VL_WIDTH'(N64);
      end else begin
         if (start_vl > VL_WIDTH'(N32)) vl_clamped = VL_WIDTH'(N32);
      end
   end

   always_comb begin
      start_en = '0;
      run_en   = '0;
      for (int i = 0; i < N32; i++) begin
`ifdef VECTOR_SQRT_MASK_EN
         start_en[i] = (VL_WIDTH'(i) < vl_clamped) && (start_vm || v0_mask[i]);
         run_en[i]   = (VL_WIDTH'(i) < vl_reg) && (vm_reg || mask_reg[i]);
`else
         start_en[i] = VL_WIDTH'(i) < vl_clamped;
         run_en[i]   = VL_WIDTH'(i) < vl_reg;
`endif
      end
   end

   assign first_idx = first_set(start_en, '0);
   assign next_idx  = first_set(run_en, index + VL_WIDTH'(1));

   // Operand is derived from latched state only, so it cannot move while a request waits.
   always_comb begin
      core_operand = '0;
      for (int i = 0; i < N32; i++) begin
         if (!sew64_reg && index == VL_WIDTH'(i)) core_operand = {32'b0, src[32*i +: 32]};
      end
      for (int i = 0; i < N64; i++) begin
         if (sew64_reg && index == VL_WIDTH'(i)) core_operand = src[64*i +: 64];
      end
   end

   assign core_sew64  = sew64_reg;
   assign core_rsqrt7 = rsqrt7_reg;
   assign start_ready = (state == IDLE) && !reset;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         index          <= '0;
         vl_reg         <= '0;
         src            <= '0;
         sew64_reg      <= 1'b0;
         rsqrt7_reg     <= 1'b0;
         vd             <= '0;
         fflags         <= '0;
         core_req_valid <= 1'b0;
         done_valid     <= 1'b0;
`ifdef VECTOR_SQRT_MASK_EN
         vm_reg         <= 1'b1;
         mask_reg       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  rsqrt7_reg <= start_rsqrt7;
                  sew64_reg  <= start_sew64;
                  src        <= vs2;
                  vd         <= vd_old;
                  fflags     <= '0;
                  vl_reg     <= vl_clamped;
`ifdef VECTOR_SQRT_MASK_EN
                  vm_reg     <= start_vm;
                  mask_reg   <= v0_mask;
`endif
                  if (first_idx == NONE) begin
                     index      <= '0;
                     done_valid <= 1'b1;
                     state      <= DONE;
                  end else begin
                     index          <= first_idx;
                     core_req_valid <= 1'b1;
                     state          <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               // A kill that coincides with acceptance still leaves a response in flight.
               if (kill) begin
                  core_req_valid <= 1'b0;
                  state          <= core_req_ready ? DRAIN : IDLE;
               end else if (core_req_ready) begin
                  core_req_valid <= 1'b0;
                  state          <= WAIT;
               end
            end
            WAIT: begin
               if (kill) begin
                  state <= core_resp_valid ? IDLE : DRAIN;
               end else if (core_resp_valid) begin
                  for (int i = 0; i < N32; i++) begin
                     if (!sew64_reg && index == VL_WIDTH'(i)) vd[32*i +: 32] <= core_result[31:0];
                  end
                  for (int i = 0; i < N64; i++) begin
                     if (sew64_reg && index == VL_WIDTH'(i)) vd[64*i +: 64] <= core_result;
                  end
                  fflags <= fflags | core_fflags;
                  if (next_idx == NONE) begin
                     done_valid <= 1'b1;
                     state      <= DONE;
                  end else begin
                     index          <= next_idx;
                     core_req_valid <= 1'b1;
                     state          <= ISSUE;
                  end
               end
            end
            DONE: begin
               if (kill || done_ready) begin
                  done_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            DRAIN: begin
               if (core_resp_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
